guess_checker: RTL and testbench
================================

# guess_checker

Consumes the secret number produced by the game's random-number generator and judges player guesses against it. It latches the secret and difficulty at game start and accepts guesses over a valid/ready handshake. Each accepted guess yields a registered too-high / too-low / correct verdict. The block counts attempts against a per-difficulty limit and ends the game as won or lost. It sits between the number generator and the display/input logic of the guessing game.

## Interface
- MAX_TRIES_1, default 4: attempt limit at difficulty 1 (range 0-9)
- MAX_TRIES_2, default 7: attempt limit at difficulty 2 (range 0-99)
- MAX_TRIES_3, default 10: attempt limit at difficulty 3 (range 0-999); all limits are 1..15
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches difficulty_level and number_in and begins a game
- difficulty_level  in  2  01/10/11 = difficulty 1/2/3; 00 is invalid
- number_in  in  10  secret number from the generator; sampled only on an accepted start
- guess_valid  in  1  guess presented
- guess  in  10  player guess, unsigned
- guess_ready  out  1  high only in PLAY
- result_valid  out  1  one-cycle pulse: verdict flags updated
- too_high, too_low, correct  out  1 each  verdict for the last accepted guess; held until the next verdict or start
- invalid_guess  out  1  one-cycle pulse: guess rejected as out of range
- tries_used  out  4  accepted, in-range guesses this game
- tries_left  out  4  limit minus tries_used
- game_won, game_lost  out  1 each  level outputs, high in WON / LOST
- secret_out  out  10  latched secret while in WON or LOST; 0 otherwise

## Operation
- States: IDLE, PLAY, WON, LOST.
- Reset values:
  - state = IDLE
  - All flag and pulse outputs = 0
  - tries_used = 0
  - tries_left = 0
  - secret_out = 0
  - Latched secret, difficulty and limit = 0
- Accepted start:
  - Condition: start=1 and difficulty_level≠00, in any state (including PLAY, which restarts the game).
  - Latches secret, difficulty and the matching MAX_TRIES_n.
  - Clears tries_used and all verdict flags.
  - Sets tries_left = limit and goes to PLAY.
- start with difficulty_level=00 is ignored; state and outputs are unchanged.
- Guess acceptance: guess_valid && guess_ready. Only PLAY accepts guesses; guess_valid in other states is ignored.
- Range check against max = 9 / 99 / 999 for difficulty 1 / 2 / 3:
  - guess > max: pulse invalid_guess. No count change, no verdict change, no result_valid.
- In-range guess:
  - Compare unsigned 10-bit.
  - guess > secret → too_high.
  - guess < secret → too_low.
  - Equal → correct.
  - Exactly one flag is set; result_valid pulses; tries_used+1; tries_left−1.
- Transitions out of PLAY:
  - correct → WON. This applies even if it is the last permitted try; correct beats exhaustion.
  - Not correct and new tries_used == limit → LOST.
  - Otherwise remain in PLAY.
- WON/LOST:
  - Hold all outputs, secret_out = latched secret, guess_ready = 0.
  - Only an accepted start or reset leaves these states.
- Simultaneous start and guess_valid in PLAY: start wins; the guess is discarded and no verdict is produced.
- The secret is not range-checked. An out-of-range secret is unguessable and the game ends LOST.
- tries_used saturates at the limit; no wrap is possible.

## Timing
- Guess accepted at rising edge N:
  - result_valid, flags, tries_used, tries_left and the state change are all visible after edge N.
  - Latency is 1 cycle.
  - guess_ready falls in that same cycle if the game ended.
- Invalid guess at edge N: invalid_guess is high for exactly the cycle after N.
- Accepted start at edge N: PLAY, guess_ready=1 and tries_left=limit after edge N. A guess can be accepted at edge N+1.
- Back-to-back guesses, one per cycle, are supported in PLAY.
- Reset asserted at any edge overrides start and guesses. Outputs take reset values after that edge, including mid-game.

## Test plan
- Reset, then start with difficulty 01 and secret 7 → next cycle: PLAY, guess_ready=1, tries_left=4, tries_used=0, all flags 0.
- Difficulty 01, secret 7, guesses 3, 9, 7 on consecutive cycles:
  - 3 → too_low, tries_used=1.
  - 9 → too_high, tries_used=2.
  - 7 → correct, game_won=1, secret_out=7, tries_used=3, guess_ready=0.
- Difficulty 01, secret 5, four guesses of 0:
  - Each produces too_low and result_valid.
  - After the 4th: game_lost=1, tries_left=0, secret_out=5.
  - A 5th guess is ignored.
- Difficulty 10, secret 42, guess 150:
  - invalid_guess pulses one cycle; tries_used stays 0; no result_valid.
  - Then guess 42 → correct, tries_used=1.
- Difficulty 11, secret 999, limit 10: nine wrong guesses, then 999 on the 10th → WON, not LOST.
- Mid-game:
  - start with difficulty 00 → ignored.
  - start and guess_valid together in PLAY → new game, tries_used=0, no verdict.
  - reset in PLAY → IDLE, all outputs 0.

Source files
------------

// File: rtl/guess_checker.sv
// Judges player guesses against a latched secret number, counting attempts
// against a per-difficulty limit and ending the game as won or lost.
module guess_checker #(
    parameter int MAX_TRIES_1 = 4,
    parameter int MAX_TRIES_2 = 7,
    parameter int MAX_TRIES_3 = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] difficulty_level,
    input  logic [9:0] number_in,
    input  logic       guess_valid,
    input  logic [9:0] guess,
    output logic       guess_ready,
    output logic       result_valid,
    output logic       too_high,
    output logic       too_low,
    output logic       correct,
    output logic       invalid_guess,
    output logic [3:0] tries_used,
    output logic [3:0] tries_left,
    output logic       game_won,
    output logic       game_lost,
    output logic [9:0] secret_out
);

    typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

    state_t     state, state_n;
    logic [9:0] secret, secret_n;
    logic [1:0] diff, diff_n;
    logic [3:0] limit, limit_n;
    logic [3:0] tries_n;
    logic       too_high_n, too_low_n, correct_n;
    logic       result_valid_n, invalid_guess_n;
    logic [9:0] max_val;

    always_comb begin
        case (diff)
            2'd1:    max_val = 10'd9;
            2'd2:    max_val = 10'd99;
            2'd3:    max_val = 10'd999;
            default: max_val = 10'd0;
        endcase
    end

    // NOTE: every signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n         = state;
        secret_n        = secret;
        diff_n          = diff;
        limit_n         = limit;
        tries_n         = tries_used;
        too_high_n      = too_high;
        too_low_n       = too_low;
        correct_n       = correct;
        result_valid_n  = 1'b0;
        invalid_guess_n = 1'b0;

        if (start && difficulty_level != 2'b00) begin
            // A start always wins, even over a guess presented in the same cycle.
            secret_n   = number_in;
            diff_n     = difficulty_level;
            case (difficulty_level)
                2'd1:    limit_n = 4'(MAX_TRIES_1);
                2'd2:    limit_n = 4'(MAX_TRIES_2);
                default: limit_n = 4'(MAX_TRIES_3);
            endcase
            tries_n    = 4'd0;
            too_high_n = 1'b0;
            too_low_n  = 1'b0;
            correct_n  = 1'b0;
            state_n    = PLAY;
        end else if (state == PLAY && guess_valid) begin
            if (guess > max_val) begin
                invalid_guess_n = 1'b1;
            end else begin
                too_high_n     = guess > secret;
                too_low_n      = guess < secret;
                correct_n      = guess == secret;
                result_valid_n = 1'b1;
                tries_n        = tries_used + 4'd1;
                // Correct on the final permitted try still counts as a win.
                if (guess == secret)
                    state_n = WON;
                else if (tries_n == limit)
                    state_n = LOST;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            secret        <= '0;
            diff          <= '0;
            limit         <= '0;
            tries_used    <= '0;
            too_high      <= 1'b0;
            too_low       <= 1'b0;
            correct       <= 1'b0;
            result_valid  <= 1'b0;
            invalid_guess <= 1'b0;
        end else begin
            state         <= state_n;
            secret        <= secret_n;
            diff          <= diff_n;
            limit         <= limit_n;
            tries_used    <= tries_n;
            too_high      <= too_high_n;
            too_low       <= too_low_n;
            correct       <= correct_n;
            result_valid  <= result_valid_n;
            invalid_guess <= invalid_guess_n;
        end
    end

    assign tries_left  = limit - tries_used;
    assign guess_ready = (state == PLAY);
    assign game_won    = (state == WON);
    assign game_lost   = (state == LOST);
    assign secret_out  = (state == WON || state == LOST) ? secret : 10'd0;

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: a reference game model pushes expected
// verdicts to a scoreboard that is popped whenever result_valid fires.
module tb_guess_checker;

    logic       clk = 1'b0;
    logic       reset, start, guess_valid;
    logic [1:0] difficulty_level;
    logic [9:0] number_in, guess;
    logic       guess_ready, result_valid, too_high, too_low, correct, invalid_guess;
    logic [3:0] tries_used, tries_left;
    logic       game_won, game_lost;
    logic [9:0] secret_out;

    guess_checker dut (
        .clk(clk), .reset(reset), .start(start), .difficulty_level(difficulty_level),
        .number_in(number_in), .guess_valid(guess_valid), .guess(guess),
        .guess_ready(guess_ready), .result_valid(result_valid), .too_high(too_high),
        .too_low(too_low), .correct(correct), .invalid_guess(invalid_guess),
        .tries_used(tries_used), .tries_left(tries_left), .game_won(game_won),
        .game_lost(game_lost), .secret_out(secret_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hi, lo, eq;
        logic [3:0] used;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: 0 idle, 1 play, 2 won, 3 lost.
    int         m_st, m_limit, m_max, m_tries;
    logic [9:0] m_secret;
    logic       m_hi, m_lo, m_eq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st = 0; m_limit = 0; m_max = 0; m_tries = 0; m_secret = '0;
        m_hi = 0; m_lo = 0; m_eq = 0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        logic [3:0] left_exp;
        left_exp = 4'(m_limit - m_tries);
        check({tag, ".too_high"}, too_high, m_hi);
        check({tag, ".too_low"}, too_low, m_lo);
        check({tag, ".correct"}, correct, m_eq);
        check({tag, ".tries_used"}, tries_used, m_tries);
        check({tag, ".tries_left"}, tries_left, left_exp);
        check({tag, ".guess_ready"}, guess_ready, m_st == 1);
        check({tag, ".game_won"}, game_won, m_st == 2);
        check({tag, ".game_lost"}, game_lost, m_st == 3);
        check({tag, ".secret_out"}, secret_out, (m_st >= 2) ? m_secret : 10'd0);
    endtask

    // Drive start (optionally with a simultaneous guess) for one cycle.
    task automatic do_start(input string tag, input logic [1:0] d, input logic [9:0] n,
                            input logic gv, input logic [9:0] g);
        if (d != 2'b00) begin
            m_st = 1; m_secret = n; m_tries = 0; m_hi = 0; m_lo = 0; m_eq = 0;
            m_limit = (d == 2'd1) ? 4 : (d == 2'd2) ? 7 : 10;
            m_max   = (d == 2'd1) ? 9 : (d == 2'd2) ? 99 : 999;
        end
        start = 1'b1; difficulty_level = d; number_in = n; guess_valid = gv; guess = g;
        step();
        start = 1'b0; guess_valid = 1'b0;
        check({tag, ".result_valid"}, result_valid, 1'b0);
        check({tag, ".invalid_guess"}, invalid_guess, 1'b0);
        check_state(tag);
    endtask

    task automatic do_guess(input string tag, input logic [9:0] g);
        logic exp_rv, exp_inv;
        exp_t e, got;
        exp_rv = 0; exp_inv = 0;
        if (m_st == 1) begin
            if (int'(g) > m_max) begin
                exp_inv = 1;
            end else begin
                m_hi = g > m_secret; m_lo = g < m_secret; m_eq = g == m_secret;
                m_tries++;
                e.hi = m_hi; e.lo = m_lo; e.eq = m_eq; e.used = 4'(m_tries);
                sb.push_back(e);
                exp_rv = 1;
                if (m_eq) m_st = 2;
                else if (m_tries == m_limit) m_st = 3;
            end
        end
        guess_valid = 1'b1; guess = g;
        step();
        guess_valid = 1'b0;
        check({tag, ".result_valid"}, result_valid, exp_rv);
        check({tag, ".invalid_guess"}, invalid_guess, exp_inv);
        if (result_valid === 1'b1) begin
            check({tag, ".sb_has_entry"}, sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check({tag, ".sb_hi"}, too_high, got.hi);
                check({tag, ".sb_lo"}, too_low, got.lo);
                check({tag, ".sb_eq"}, correct, got.eq);
                check({tag, ".sb_used"}, tries_used, got.used);
            end
        end
        check_state(tag);
    endtask

    task automatic idle_cycle(input string tag);
        step();
        check({tag, ".result_valid"}, result_valid, 1'b0);
        check({tag, ".invalid_guess"}, invalid_guess, 1'b0);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag, input logic with_start);
        reset = 1'b1; start = with_start; difficulty_level = 2'd1; number_in = 10'd3;
        guess_valid = with_start; guess = 10'd3;
        step();
        reset = 1'b0; start = 1'b0; guess_valid = 1'b0;
        model_reset();
        check({tag, ".result_valid"}, result_valid, 1'b0);
        check({tag, ".invalid_guess"}, invalid_guess, 1'b0);
        check_state(tag);
    endtask

    initial begin
        reset = 0; start = 0; guess_valid = 0; difficulty_level = 0; number_in = 0; guess = 0;
        model_reset();
        do_reset("rst", 1'b0);
        idle_cycle("idle");
        do_guess("idle_guess", 10'd4);

        // Difficulty 1, secret 7: low, high, correct.
        do_start("s1", 2'd1, 10'd7, 1'b0, 10'd0);
        do_guess("g3", 10'd3);
        do_guess("g9", 10'd9);
        do_guess("g7", 10'd7);
        do_guess("won_ignored", 10'd7);

        // Difficulty 1, secret 5: exhaust four tries.
        do_start("s2", 2'd1, 10'd5, 1'b0, 10'd0);
        for (int i = 0; i < 4; i++) do_guess($sformatf("lose%0d", i), 10'd0);
        do_guess("lost_ignored", 10'd0);
        idle_cycle("lost_hold");

        // Difficulty 2, secret 42: out-of-range then correct.
        do_start("s3", 2'd2, 10'd42, 1'b0, 10'd0);
        do_guess("g150", 10'd150);
        idle_cycle("inv_pulse_end");
        do_guess("g99_low", 10'd99);
        do_guess("g42", 10'd42);

        // Difficulty 3, secret 999: correct on the 10th (final) try.
        do_start("s4", 2'd3, 10'd999, 1'b0, 10'd0);
        do_guess("g1000", 10'd1000);
        for (int i = 0; i < 9; i++) do_guess($sformatf("d3w%0d", i), 10'(i * 100));
        do_guess("g999_last", 10'd999);

        // Mid-game controls.
        do_start("s5", 2'd2, 10'd10, 1'b0, 10'd0);
        do_guess("m_g50", 10'd50);
        do_start("start00", 2'd0, 10'd77, 1'b0, 10'd0);
        do_guess("m_g5", 10'd5);
        do_start("restart_gv", 2'd1, 10'd2, 1'b1, 10'd2);
        do_guess("after_restart", 10'd2);
        do_start("s6", 2'd3, 10'd500, 1'b0, 10'd0);
        do_guess("m_g600", 10'd600);
        do_reset("rst_mid", 1'b1);
        idle_cycle("post_rst");

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
